// File: rtl/de2_70_nios2_debug_mem_arbiter.sv
// de2_70_nios2_debug_mem_arbiter: shares the single-port debug RAM
// between the JTAG command path and the CPU debug monitor.
module de2_70_nios2_debug_mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    JTAG_ACC,
    CPU_ACC,
    RD_WAIT
  } state_e;

  localparam logic [3:0] STREAK_LIM = 4'(STARVE_LIMIT);

  state_e              state_q;
  logic                own_jtag_q;
  logic                acc_wr_q;
  logic [ADDR_W-1:0]   acc_addr_q;
  logic [DATA_W-1:0]   acc_wdata_q;

  logic [ADDR_W-1:0]   jaddr_q, jaddr_d;
  logic                jpend_q, jpend_d;
  logic                jwr_q, jwr_d;
  logic [DATA_W-1:0]   jwdata_q, jwdata_d;
  logic [3:0]          jstreak_q, jstreak_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;

  logic                cpu_ack_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   mon_q;

  logic                take_a, take_b;
  logic                jcomplete, jbusy;
  logic                cmd_rd, cmd_wr;
  logic                accept, drop;
  logic                jtag_grant, cpu_grant;
  logic                jdo_unused;

  assign take_a = take_action_ocimem_a;
  assign take_b = take_action_ocimem_b;
  assign jdo_unused = ^{jdo[37], jdo[2:0]};

  always_comb begin
    jcomplete = ((state_q == JTAG_ACC) && acc_wr_q)
             || ((state_q == RD_WAIT) && own_jtag_q);
    // the slot frees on the completion edge, so a command can land there
    jbusy  = jpend_q && !jcomplete;
    cmd_rd = take_a && jdo[35];
    cmd_wr = take_b && !take_a;
    accept = (cmd_rd || cmd_wr) && !jbusy;
    drop   = (take_a && take_b)
          || ((cmd_rd || cmd_wr) && jbusy);
    jtag_grant = (state_q == IDLE) && jpend_q
              && (!cpu_req || (jstreak_q < STREAK_LIM));
    cpu_grant  = (state_q == IDLE) && !jtag_grant
              && cpu_req && !cpu_ack_q;
  end

  always_comb begin
    jaddr_d = jaddr_q;
    if (take_a) begin
      jaddr_d = jdo[10 +: ADDR_W];
    end else if ((state_q == JTAG_ACC) && acc_wr_q) begin
      jaddr_d = jaddr_q + 1'b1;
    end

    jpend_d = jpend_q;
    ready_d = ready_q;
    if (jcomplete) begin
      jpend_d = 1'b0;
      ready_d = 1'b1;
    end
    if (accept) begin
      jpend_d = 1'b1;
      ready_d = 1'b0;
    end

    jwr_d    = jwr_q;
    jwdata_d = jwdata_q;
    if (accept) begin
      jwr_d    = cmd_wr;
      jwdata_d = jdo[3 +: DATA_W];
    end

    err_d = drop || (err_q && !(take_a && jdo[36]));

    jstreak_d = jstreak_q;
    if (cpu_grant || !cpu_req) begin
      jstreak_d = 4'd0;
    end else if (jtag_grant) begin
      jstreak_d = jstreak_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      own_jtag_q  <= 1'b0;
      acc_wr_q    <= 1'b0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
      jaddr_q     <= '0;
      jpend_q     <= 1'b0;
      jwr_q       <= 1'b0;
      jwdata_q    <= '0;
      jstreak_q   <= 4'd0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      mon_q       <= '0;
    end else begin
      jaddr_q   <= jaddr_d;
      jpend_q   <= jpend_d;
      jwr_q     <= jwr_d;
      jwdata_q  <= jwdata_d;
      jstreak_q <= jstreak_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      cpu_ack_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (jtag_grant) begin
            state_q     <= JTAG_ACC;
            own_jtag_q  <= 1'b1;
            acc_wr_q    <= jwr_q;
            acc_addr_q  <= jaddr_q;
            acc_wdata_q <= jwdata_q;
          end else if (cpu_grant) begin
            state_q     <= CPU_ACC;
            own_jtag_q  <= 1'b0;
            acc_wr_q    <= cpu_write;
            acc_addr_q  <= cpu_addr;
            acc_wdata_q <= cpu_wdata;
          end
        end
        JTAG_ACC: begin
          state_q <= acc_wr_q ? IDLE : RD_WAIT;
        end
        CPU_ACC: begin
          state_q <= acc_wr_q ? IDLE : RD_WAIT;
          if (acc_wr_q) begin
            cpu_ack_q <= 1'b1;
          end
        end
        RD_WAIT: begin
          state_q <= IDLE;
          if (own_jtag_q) begin
            mon_q <= ram_rdata;
          end else begin
            cpu_rdata_q <= ram_rdata;
            cpu_ack_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign ram_addr  = acc_addr_q;
  assign ram_wdata = acc_wdata_q;
  assign ram_wren  = acc_wr_q
                  && ((state_q == JTAG_ACC) || (state_q == CPU_ACC));

  assign cpu_ack       = cpu_ack_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = err_q;

endmodule

// File: tb/tb_de2_70_nios2_debug_mem_arbiter.sv
// tb_de2_70_nios2_debug_mem_arbiter: directed vector table plus
// hand sequences for overflow, starvation and reset abort.
module tb_de2_70_nios2_debug_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        ta, tbp;
  logic        cpu_req, cpu_write;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [256];
  logic        preload;

  int nchk = 0;
  int nerr = 0;

  de2_70_nios2_debug_mem_arbiter #(
    .ADDR_W(8), .DATA_W(32), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .jdo(jdo),
    .take_action_ocimem_a(ta),
    .take_action_ocimem_b(tbp),
    .cpu_req(cpu_req),
    .cpu_write(cpu_write),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata),
    .MonDReg(MonDReg),
    .monitor_ready(monitor_ready),
    .monitor_error(monitor_error),
    .ram_addr(ram_addr),
    .ram_wren(ram_wren),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // synchronous single-port RAM, one cycle read latency
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h34] <= 32'h34343434;
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  typedef enum int {OP_A, OP_B, OP_CW, OP_CR} op_e;

  typedef struct {
    op_e         op;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        rd;
    logic [7:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  function automatic logic [37:0] mk_a(input logic [7:0] a,
                                       input logic rd,
                                       input logic clr);
    logic [37:0] j;
    j = '0;
    j[17:10] = a;
    j[35] = rd;
    j[36] = clr;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string t);
    chkb({t, "_ack"}, cpu_ack, 1'b0);
    chk({t, "_rdata"}, cpu_rdata, 32'h0);
    chk({t, "_mon"}, MonDReg, 32'h0);
    chkb({t, "_rdy"}, monitor_ready, 1'b0);
    chkb({t, "_err"}, monitor_error, 1'b0);
    chk({t, "_raddr"}, {24'h0, ram_addr}, 32'h0);
    chkb({t, "_wren"}, ram_wren, 1'b0);
    chk({t, "_wdata"}, ram_wdata, 32'h0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    unique case (v.op)
      OP_A: begin
        @(negedge clk); jdo = mk_a(v.addr, v.rd, 1'b0); ta = 1'b1;
        @(negedge clk); ta = 1'b0; jdo = '0;
        if (v.rd) begin
          chkb({t, "_rdy_clr"}, monitor_ready, 1'b0);
          @(negedge clk);
          chk({t, "_raddr"}, {24'h0, ram_addr}, {24'h0, v.exp_addr});
          chkb({t, "_nowr"}, ram_wren, 1'b0);
          @(negedge clk);
          @(negedge clk);
          chk({t, "_mon"}, MonDReg, v.exp_data);
          chkb({t, "_rdy"}, monitor_ready, 1'b1);
        end else begin
          chkb({t, "_err"}, monitor_error, 1'b0);
        end
      end
      OP_B: begin
        @(negedge clk); jdo = mk_b(v.data); tbp = 1'b1;
        @(negedge clk); tbp = 1'b0; jdo = '0;
        chkb({t, "_rdy_clr"}, monitor_ready, 1'b0);
        @(negedge clk);
        chkb({t, "_wren"}, ram_wren, 1'b1);
        chk({t, "_waddr"}, {24'h0, ram_addr}, {24'h0, v.exp_addr});
        chk({t, "_wdata"}, ram_wdata, v.data);
        @(negedge clk);
        chkb({t, "_rdy"}, monitor_ready, 1'b1);
        chkb({t, "_wren_off"}, ram_wren, 1'b0);
      end
      OP_CW: begin
        @(negedge clk);
        cpu_req = 1'b1; cpu_write = 1'b1;
        cpu_addr = v.addr; cpu_wdata = v.data;
        @(negedge clk);
        chkb({t, "_wren"}, ram_wren, 1'b1);
        chk({t, "_waddr"}, {24'h0, ram_addr}, {24'h0, v.exp_addr});
        @(negedge clk);
        chkb({t, "_ack"}, cpu_ack, 1'b1);
        cpu_req = 1'b0; cpu_write = 1'b0;
      end
      OP_CR: begin
        @(negedge clk);
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = v.addr;
        @(negedge clk);
        chk({t, "_raddr"}, {24'h0, ram_addr}, {24'h0, v.exp_addr});
        chkb({t, "_nowr"}, ram_wren, 1'b0);
        @(negedge clk);
        chkb({t, "_noack"}, cpu_ack, 1'b0);
        @(negedge clk);
        chkb({t, "_ack"}, cpu_ack, 1'b1);
        chk({t, "_rdata"}, cpu_rdata, v.exp_data);
        cpu_req = 1'b0;
      end
    endcase
    repeat (2) @(negedge clk);
    chkb({t, "_ack_once"}, cpu_ack, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[17];
    vec_t tmp;
    int issued, wr_seen, gr_while, acks, overlap;
    logic [31:0] got_rd;

    vecs[0]  = '{OP_A,  8'h10, 32'h0,        1'b0, 8'h00, 32'h0};
    vecs[1]  = '{OP_B,  8'h00, 32'hA5A5A5A5, 1'b0, 8'h10, 32'h0};
    vecs[2]  = '{OP_B,  8'h00, 32'h5A5A5A5A, 1'b0, 8'h11, 32'h0};
    vecs[3]  = '{OP_B,  8'h00, 32'h12121212, 1'b0, 8'h12, 32'h0};
    vecs[4]  = '{OP_A,  8'h10, 32'h0,        1'b1, 8'h10, 32'hA5A5A5A5};
    vecs[5]  = '{OP_B,  8'h00, 32'h11111111, 1'b0, 8'h10, 32'h0};
    vecs[6]  = '{OP_A,  8'h11, 32'h0,        1'b1, 8'h11, 32'h5A5A5A5A};
    vecs[7]  = '{OP_A,  8'hFF, 32'h0,        1'b0, 8'h00, 32'h0};
    vecs[8]  = '{OP_B,  8'h00, 32'hDEADBEEF, 1'b0, 8'hFF, 32'h0};
    vecs[9]  = '{OP_B,  8'h00, 32'hCAFEF00D, 1'b0, 8'h00, 32'h0};
    vecs[10] = '{OP_A,  8'hFF, 32'h0,        1'b1, 8'hFF, 32'hDEADBEEF};
    vecs[11] = '{OP_A,  8'h00, 32'h0,        1'b1, 8'h00, 32'hCAFEF00D};
    vecs[12] = '{OP_CW, 8'h20, 32'h13572468, 1'b0, 8'h20, 32'h0};
    vecs[13] = '{OP_CR, 8'h20, 32'h0,        1'b0, 8'h20, 32'h13572468};
    vecs[14] = '{OP_CR, 8'h12, 32'h0,        1'b0, 8'h12, 32'h12121212};
    vecs[15] = '{OP_A,  8'h20, 32'h0,        1'b1, 8'h20, 32'h13572468};
    vecs[16] = '{OP_CR, 8'h10, 32'h0,        1'b0, 8'h10, 32'h11111111};

    reset = 1'b1; preload = 1'b1;
    jdo = '0; ta = 1'b0; tbp = 1'b0;
    cpu_req = 1'b0; cpu_write = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0; preload = 1'b0;
    @(negedge clk);
    chk_zero("rst");

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // overflow: second write while one is pending
    tmp = '{OP_A, 8'h30, 32'h0, 1'b0, 8'h00, 32'h0};
    run_vec(100, tmp);
    @(negedge clk); jdo = mk_b(32'h0BAD0001); tbp = 1'b1;
    @(negedge clk); jdo = mk_b(32'h0BAD0002); tbp = 1'b1;
    @(negedge clk); tbp = 1'b0; jdo = '0;
    repeat (4) @(negedge clk);
    chkb("ovf_err", monitor_error, 1'b1);
    chk("ovf_first", mem[8'h30], 32'h0BAD0001);
    chk("ovf_second", mem[8'h31], 32'h0);
    chkb("ovf_rdy", monitor_ready, 1'b1);

    @(negedge clk); jdo = mk_a(8'h34, 1'b0, 1'b1); ta = 1'b1;
    @(negedge clk); ta = 1'b0; jdo = '0;
    chkb("clr_err", monitor_error, 1'b0);

    // a and b together: a read executes, b dropped
    @(negedge clk); jdo = mk_a(8'h34, 1'b1, 1'b0); ta = 1'b1; tbp = 1'b1;
    @(negedge clk); ta = 1'b0; tbp = 1'b0; jdo = '0;
    repeat (5) @(negedge clk);
    chkb("ab_err", monitor_error, 1'b1);
    chk("ab_mon", MonDReg, 32'h34343434);
    chk("ab_nowrite", mem[8'h34], 32'h34343434);
    @(negedge clk); jdo = mk_a(8'h40, 1'b0, 1'b1); ta = 1'b1;
    @(negedge clk); ta = 1'b0; jdo = '0;
    chkb("clr_err2", monitor_error, 1'b0);
    repeat (2) @(negedge clk);

    // starvation: JTAG write stream to 0x40.. with a held CPU read
    issued = 0; wr_seen = 0; gr_while = 0; acks = 0; overlap = 0;
    got_rd = '0;
    @(negedge clk); jdo = mk_b(32'hB0000000); tbp = 1'b1; issued = 1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      tbp = 1'b0;
      if (cpu_ack) begin
        acks++;
        got_rd = cpu_rdata;
        if (ram_wren) overlap++;
      end
      if (ram_wren) begin
        wr_seen++;
        if (cpu_req && acks == 0) gr_while++;
      end
      if (cpu_ack) cpu_req = 1'b0;
      if (ram_wren && issued < 10) begin
        jdo = mk_b(32'hB0000000 + 32'(issued));
        tbp = 1'b1;
        issued++;
        if (issued == 2) begin
          cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h20;
        end
      end
    end
    cpu_req = 1'b0; jdo = '0;
    chk("stv_acks", 32'(acks), 32'd1);
    chk("stv_grants", 32'(gr_while), 32'd4);
    chk("stv_rdata", got_rd, 32'h13572468);
    chk("stv_writes", 32'(wr_seen), 32'd10);
    chk("stv_overlap", 32'(overlap), 32'd0);
    chkb("stv_err", monitor_error, 1'b0);
    chk("stv_mem0", mem[8'h40], 32'hB0000000);
    chk("stv_mem9", mem[8'h49], 32'hB0000009);

    // reset while a CPU read sits in RD_WAIT
    @(negedge clk);
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 8'h12;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk_zero("rst_mid");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chkb("rst_noack", cpu_ack, 1'b0);
    tmp = '{OP_CR, 8'h12, 32'h0, 1'b0, 8'h12, 32'h12121212};
    run_vec(200, tmp);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/de2_70_nios2_debug_mem_arbiter.md
# de2_70_nios2_debug_mem_arbiter

Shares the single-port 256x32 on-chip debug RAM of the Nios II debug module between two requesters: the JTAG debug path (sysclk-side command pulses plus the 38-bit `jdo` shift-register image) and the CPU-side debug monitor. It holds one pending JTAG command, arbitrates with bounded CPU starvation and sequences each RAM access. It returns JTAG read data on `MonDReg` and completion status on `monitor_ready` / `monitor_error`.

## Interface
Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 32, RAM data width
- STARVE_LIMIT, 4, max consecutive JTAG grants while `cpu_req` is pending (range 1–15)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- jdo  in  38  JTAG data image, valid in the cycle a take_action pulse is high
- take_action_ocimem_a  in  1  one-cycle pulse: address/read command
- take_action_ocimem_b  in  1  one-cycle pulse: write command
- cpu_req  in  1  CPU access request; held until `cpu_ack`
- cpu_write  in  1  1 = write, 0 = read; stable while `cpu_req`
- cpu_addr  in  ADDR_W  CPU address; stable while `cpu_req`
- cpu_wdata  in  DATA_W  CPU write data; stable while `cpu_req`
- cpu_ack  out  1  one-cycle completion pulse, registered
- cpu_rdata  out  DATA_W  CPU read data, valid with `cpu_ack`, registered
- MonDReg  out  32  last JTAG read data
- monitor_ready  out  1  last JTAG command completed
- monitor_error  out  1  sticky JTAG command overflow flag
- ram_addr  out  ADDR_W  RAM address
- ram_wren  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data; synchronous RAM, 1-cycle read latency

## Operation
JTAG command capture:
- `take_action_ocimem_a` loads jaddr ← jdo[17:10].
  - If jdo[35]=1, it also queues a read of jaddr.
  - If jdo[36]=1, it also clears `monitor_error`.
- `take_action_ocimem_b` queues a write of jdo[34:3] to jaddr.
- Queuing sets jpend and clears `monitor_ready`.
- A command arriving while jpend=1 is dropped and sets `monitor_error`; the jaddr load and the error clear still take effect.
- `a` and `b` pulsing in the same cycle: `a` is processed, `b` is dropped, `monitor_error` is set.
- After a granted JTAG write, jaddr increments modulo 2^ADDR_W (255 → 0). Reads do not increment jaddr.

State machine: IDLE, JTAG_ACC, CPU_ACC, RD_WAIT. `ram_addr`, `ram_wren` and `ram_wdata` are decoded from the registered state and latched request.
- IDLE: grant JTAG if jpend and (!cpu_req or jstreak < STARVE_LIMIT). Otherwise grant the CPU if cpu_req and !cpu_ack. Otherwise stay in IDLE.
- jstreak increments on each JTAG grant while cpu_req=1. It clears on a CPU grant or when cpu_req=0.
- JTAG_ACC / CPU_ACC: drive the address.
  - Write: `ram_wren`=1 for exactly this cycle, then go to IDLE.
  - Read: go to RD_WAIT.
- RD_WAIT: capture `ram_rdata` into MonDReg (JTAG) or cpu_rdata (CPU), then go to IDLE.
- Completion, registered and visible in the next cycle:
  - JTAG: `monitor_ready` ← 1, jpend ← 0.
  - CPU: `cpu_ack` pulses for 1 cycle.
- IDLE ignores `cpu_req` in the cycle `cpu_ack`=1, so a held request is not re-granted.

Reset values: state IDLE, jaddr 0, jpend 0, jstreak 0. All outputs are 0, including `MonDReg`, `cpu_rdata`, `monitor_ready` and `monitor_error`.
- Reset mid-access aborts the access: no ack, no `monitor_ready`, no further writes after the reset edge.

## Timing
Counting from a pulse or request at cycle N, with no contention:
- JTAG write: ram_wren at N+2; monitor_ready=1 at N+3; jaddr already incremented at N+3.
- JTAG read: ram_addr at N+2; MonDReg valid and monitor_ready=1 at N+4.
- CPU write (cpu_req first high at N, state IDLE): ram_wren at N+1; cpu_ack at N+2.
- CPU read: ram_addr at N+1; cpu_ack and cpu_rdata at N+3.

Rules:
- A new JTAG command may be accepted in the same cycle jpend clears.
- Throughput: at most one RAM access in flight.
- With a continuous JTAG stream and cpu_req held, the CPU is granted within STARVE_LIMIT JTAG accesses.
- `cpu_ack` never coincides with `ram_wren` for a different requester.

## Test plan
- Reset, then `a` with jdo[17:10]=0x10, followed by `b` writes 0xA5A5A5A5 and 0x5A5A5A5A → RAM[0x10] and RAM[0x11] written; monitor_ready rises after each write; jaddr=0x12.
- `a` with jdo[17:10]=0x10 and jdo[35]=1 → MonDReg=0xA5A5A5A5 at N+4; jaddr stays 0x10.
- jaddr=0xFF, `b` write → RAM[0xFF] written; jaddr wraps to 0x00.
- Second `b` while jpend=1, and also `a`+`b` in the same cycle → monitor_error=1 and only the first command executes. `a` with jdo[36]=1 → monitor_error=0.
- cpu_req held as a read of 0x20 against 10 back-to-back JTAG writes with STARVE_LIMIT=4 → cpu_ack with the correct data after no more than 4 JTAG grants; exactly one ack per request.
- Reset asserted during RD_WAIT of a CPU read → no cpu_ack; all outputs 0 on the next cycle; a subsequent read completes normally.
